reservation_station_bank: RTL

//  Receiving end of the issue-queue dispatch interface: six reservation stations (STORE_1/2, LOAD_1/2, ALU_1/2).

---
 rtl/reservation_station_bank_pkg.sv | 49 ++++
 rtl/reservation_station_bank_rs_entry.sv | 107 ++++++++++
 rtl/reservation_station_bank.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/reservation_station_bank_pkg.sv
// Shared types for the reservation station bank: station tags, entry states, dispatched task.
// No logic beyond a CDB tag-match helper; zero latency.
// No flow control lives here.
package cpu_types;

  localparam int NUM_RS = 6;

  // Station tags double as CDB producer IDs; RS_BUSY bit i follows this encoding.
  typedef enum logic [2:0] {
    STORE_1 = 3'd0,
    STORE_2 = 3'd1,
    LOAD_1  = 3'd2,
    LOAD_2  = 3'd3,
    ALU_1   = 3'd4,
    ALU_2   = 3'd5,
    INVALID = 3'd7
  } RS_tag_t;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    EXEC  = 2'd3
  } rs_state_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_SLT   = 4'd6,
    OP_LOAD  = 4'd7,
    OP_STORE = 4'd8
  } opcode_t;

  typedef struct packed {
    opcode_t     op;
    logic [4:0]  rd;
    logic [11:0] imm;
  } task_t;

  // A broadcast only counts when valid and carrying a real station tag.
  function automatic logic tag_hit(input RS_tag_t q, input logic cdb_valid, input RS_tag_t cdb_tag);
    return cdb_valid && (cdb_tag != INVALID) && (q == cdb_tag);
  endfunction

endpackage

// File: rtl/reservation_station_bank_rs_entry.sv
// One reservation station: FSM, operand values/tags, task, CDB snoop and dispatch forwarding.
// Latency: dispatch or wakeup at edge t makes ready visible in cycle t+1.
// Backpressure: stays READY (payload frozen) until issue_ack; store entries free on ack.
module rs_entry
  import cpu_types::*;
#(
  parameter int      XLEN     = 32,
  parameter RS_tag_t TAG      = ALU_1,
  parameter bit      IS_STORE = 1'b0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            dispatch,
  input  task_t           disp_task,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  RS_tag_t         rs1_tag,
  input  RS_tag_t         rs2_tag,
  input  logic            cdb_valid,
  input  RS_tag_t         cdb_tag,
  input  logic [XLEN-1:0] cdb_data,
  input  logic            issue_ack,
  output logic            busy,
  output logic            ready,
  output task_t           ent_task,
  output logic [XLEN-1:0] vj,
  output logic [XLEN-1:0] vk
);

  rs_state_t       state;
  RS_tag_t         qj;
  RS_tag_t         qk;

  logic            j_fwd;
  logic            k_fwd;
  RS_tag_t         qj_disp;
  RS_tag_t         qk_disp;
  logic [XLEN-1:0] vj_disp;
  logic [XLEN-1:0] vk_disp;
  logic            j_wake;
  logic            k_wake;

  // Forwarding mux for incoming operands plus CDB snoop on pending tags.
  always_comb begin
    j_fwd   = tag_hit(rs1_tag, cdb_valid, cdb_tag);
    k_fwd   = tag_hit(rs2_tag, cdb_valid, cdb_tag);
    qj_disp = j_fwd ? INVALID : rs1_tag;
    qk_disp = k_fwd ? INVALID : rs2_tag;
    vj_disp = j_fwd ? cdb_data : rs1_val;
    vk_disp = k_fwd ? cdb_data : rs2_val;
    j_wake  = tag_hit(qj, cdb_valid, cdb_tag);
    k_wake  = tag_hit(qk, cdb_valid, cdb_tag);
  end

  // Entry FSM: FREE -> WAIT/READY -> EXEC -> FREE (stores go READY -> FREE).
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= FREE;
      qj       <= INVALID;
      qk       <= INVALID;
      vj       <= '0;
      vk       <= '0;
      ent_task <= '0;
    end else begin
      case (state)
        FREE: begin
          if (dispatch) begin
            ent_task <= disp_task;
            qj       <= qj_disp;
            qk       <= qk_disp;
            vj       <= vj_disp;
            vk       <= vk_disp;
            state    <= ((qj_disp == INVALID) && (qk_disp == INVALID)) ? READY : WAIT;
          end
        end
        WAIT: begin
          if (j_wake) begin
            qj <= INVALID;
            vj <= cdb_data;
          end
          if (k_wake) begin
            qk <= INVALID;
            vk <= cdb_data;
          end
          if (((qj == INVALID) || j_wake) && ((qk == INVALID) || k_wake)) begin
            state <= READY;
          end
        end
        READY: begin
          if (issue_ack) begin
            state <= IS_STORE ? FREE : EXEC;
          end
        end
        EXEC: begin
          if (tag_hit(TAG, cdb_valid, cdb_tag)) begin
            state <= FREE;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

  assign busy  = (state != FREE);
  assign ready = (state == READY);

endmodule

// File: rtl/reservation_station_bank.sv
// Six reservation stations fed by the dispatcher, issuing to an ALU port and a shared MEM port.
// Latency: dispatch at edge t -> busy and earliest issue request in cycle t+1.
// Backpressure: VALID/READY per port; grant locked and payload stable until handshake.
module reservation_station_bank
  import cpu_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  task_t             DISPATCH_TASK,
  input  RS_tag_t           DEST_RS,
  input  logic [XLEN-1:0]   RS1_VAL,
  input  logic [XLEN-1:0]   RS2_VAL,
  input  RS_tag_t           RS1_TAG,
  input  RS_tag_t           RS2_TAG,
  input  logic              CDB_VALID,
  input  RS_tag_t           CDB_TAG,
  input  logic [XLEN-1:0]   CDB_DATA,
  output logic [NUM_RS-1:0] RS_BUSY,
  output logic              DISPATCH_ERR,
  output logic              ALU_VALID,
  input  logic              ALU_READY,
  output task_t             ALU_TASK,
  output logic [XLEN-1:0]   ALU_A,
  output logic [XLEN-1:0]   ALU_B,
  output RS_tag_t           ALU_TAG,
  output logic              MEM_VALID,
  input  logic              MEM_READY,
  output task_t             MEM_TASK,
  output logic [XLEN-1:0]   MEM_A,
  output logic [XLEN-1:0]   MEM_B,
  output RS_tag_t           MEM_TAG
);

  logic [NUM_RS-1:0] ent_busy;
  logic [NUM_RS-1:0] ent_ready;
  logic [NUM_RS-1:0] disp_en;
  logic [NUM_RS-1:0] issue_ack;
  task_t             ent_task [NUM_RS];
  logic [XLEN-1:0]   ent_vj   [NUM_RS];
  logic [XLEN-1:0]   ent_vk   [NUM_RS];

  logic [2:0]        dest_idx;
  logic              dest_ok;
  logic              disp_err_nxt;

  // ALU arbiter state: pointer 0 = ALU_1 first, 1 = ALU_2 first.
  logic              alu_ptr;
  logic              alu_lock_vld;
  logic              alu_lock_idx;
  logic [1:0]        alu_rdy;
  logic              alu_alt;
  logic              alu_vld;
  logic              alu_sel;
  logic              alu_hs;

  // MEM arbiter state over station indices 0..3.
  logic [1:0]        mem_ptr;
  logic              mem_lock_vld;
  logic [1:0]        mem_lock_idx;
  logic [3:0]        mem_rdy;
  logic [1:0]        mem_cand;
  logic              mem_vld;
  logic [1:0]        mem_sel;
  logic              mem_hs;

  for (genvar i = 0; i < NUM_RS; i++) begin : g_rs
    rs_entry #(
      .XLEN     (XLEN),
      .TAG      (RS_tag_t'(i)),
      .IS_STORE (i < 2)
    ) u_entry (
      .CLK       (CLK),
      .RST       (RST),
      .dispatch  (disp_en[i]),
      .disp_task (DISPATCH_TASK),
      .rs1_val   (RS1_VAL),
      .rs2_val   (RS2_VAL),
      .rs1_tag   (RS1_TAG),
      .rs2_tag   (RS2_TAG),
      .cdb_valid (CDB_VALID),
      .cdb_tag   (CDB_TAG),
      .cdb_data  (CDB_DATA),
      .issue_ack (issue_ack[i]),
      .busy      (ent_busy[i]),
      .ready     (ent_ready[i]),
      .ent_task  (ent_task[i]),
      .vj        (ent_vj[i]),
      .vk        (ent_vk[i])
    );
  end

  // Dispatch decode: only a free addressed station accepts; a busy one flags an error.
  always_comb begin
    dest_idx     = DEST_RS;
    dest_ok      = (dest_idx < 3'(NUM_RS));
    disp_en      = '0;
    disp_err_nxt = 1'b0;
    if (dest_ok) begin
      if (ent_busy[dest_idx]) begin
        disp_err_nxt = 1'b1;
      end else begin
        disp_en[dest_idx] = 1'b1;
      end
    end
  end

  // Error pulse is registered so it lines up with the cycle after the dropped dispatch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DISPATCH_ERR <= 1'b0;
    end else begin
      DISPATCH_ERR <= disp_err_nxt;
    end
  end

  // ALU pick: a stalled grant stays locked, otherwise round-robin from the pointer.
  always_comb begin
    alu_rdy = ent_ready[5:4];
    alu_alt = ~alu_ptr;
    alu_vld = 1'b0;
    alu_sel = alu_ptr;
    if (alu_lock_vld) begin
      alu_vld = alu_rdy[alu_lock_idx];
      alu_sel = alu_lock_idx;
    end else if (alu_rdy[alu_ptr]) begin
      alu_vld = 1'b1;
      alu_sel = alu_ptr;
    end else if (alu_rdy[alu_alt]) begin
      alu_vld = 1'b1;
      alu_sel = alu_alt;
    end
  end

  // MEM pick: scan from farthest to nearest so the candidate closest to the pointer wins.
  always_comb begin
    mem_rdy  = ent_ready[3:0];
    mem_cand = '0;
    mem_vld  = 1'b0;
    mem_sel  = mem_ptr;
    if (mem_lock_vld) begin
      mem_vld = mem_rdy[mem_lock_idx];
      mem_sel = mem_lock_idx;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        mem_cand = mem_ptr + 2'(k);
        if (mem_rdy[mem_cand]) begin
          mem_vld = 1'b1;
          mem_sel = mem_cand;
        end
      end
    end
  end

  assign alu_hs = alu_vld & ALU_READY;
  assign mem_hs = mem_vld & MEM_READY;

  // Round-robin pointers advance past the winner only on handshake; lock holds a stalled grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_ptr      <= 1'b0;
      alu_lock_vld <= 1'b0;
      alu_lock_idx <= 1'b0;
      mem_ptr      <= 2'd0;
      mem_lock_vld <= 1'b0;
      mem_lock_idx <= 2'd0;
    end else begin
      alu_lock_vld <= alu_vld & ~ALU_READY;
      alu_lock_idx <= alu_sel;
      mem_lock_vld <= mem_vld & ~MEM_READY;
      mem_lock_idx <= mem_sel;
      if (alu_hs) begin
        alu_ptr <= ~alu_sel;
      end
      if (mem_hs) begin
        mem_ptr <= mem_sel + 2'd1;
      end
    end
  end

  // Issue acknowledge routed back to the granted entry of each port.
  always_comb begin
    issue_ack = '0;
    if (alu_hs) begin
      issue_ack[{2'b10, alu_sel}] = 1'b1;
    end
    if (mem_hs) begin
      issue_ack[{1'b0, mem_sel}] = 1'b1;
    end
  end

  // Output muxes: payload zero and tag INVALID whenever the port is idle.
  always_comb begin
    ALU_VALID = alu_vld;
    ALU_TASK  = '0;
    ALU_A     = '0;
    ALU_B     = '0;
    ALU_TAG   = INVALID;
    if (alu_vld) begin
      ALU_TASK = ent_task[{2'b10, alu_sel}];
      ALU_A    = ent_vj[{2'b10, alu_sel}];
      ALU_B    = ent_vk[{2'b10, alu_sel}];
      ALU_TAG  = RS_tag_t'({2'b10, alu_sel});
    end
    MEM_VALID = mem_vld;
    MEM_TASK  = '0;
    MEM_A     = '0;
    MEM_B     = '0;
    MEM_TAG   = INVALID;
    if (mem_vld) begin
      MEM_TASK = ent_task[{1'b0, mem_sel}];
      MEM_A    = ent_vj[{1'b0, mem_sel}];
      MEM_B    = ent_vk[{1'b0, mem_sel}];
      MEM_TAG  = RS_tag_t'({1'b0, mem_sel});
    end
  end

  assign RS_BUSY = ent_busy;

endmodule
